ccw_tx: RTL and testbench

Frame transmitter directly downstream of the CCW generator. When the generator raises `ccw_tx_rdy`, the block reads the length byte from `ccw_d`, then fetches the payload bytes with `ccw_tx_en`/`ccw_clk`. It serializes SYNC, LEN, payload and checksum MSB-first onto the HSI line `tx_d`, then holds the line idle for an inter-frame gap before accepting the next frame.

---
 rtl/ccw_pkg.sv | 20 ++
 rtl/ccw_tx_ser.sv | 52 +++++
 rtl/ccw_tx.sv | 170 +++++++++++++++++
 tb/tb_ccw_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ccw_pkg.sv
// rtl/ccw_pkg.sv - shared types and constants for the CCW frame transmitter
package ccw_pkg;

    localparam int         CCW_BYTE_W       = 8;
    localparam logic [7:0] CCW_SYNC_DEFAULT = 8'h7E;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4,
        ST_GAP     = 3'd5
    } ccw_tx_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/ccw_tx_ser.sv
// rtl/ccw_tx_ser.sv - bit divider and MSB-first shifter driving the HSI line
module ccw_tx_ser
    import ccw_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CCW_BYTE_W-1:0] din,
    output logic                  tx_d,
    output logic                  byte_end,
    output logic                  byte_pre
);

    localparam int              DIV_W    = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(BIT_DIV - 2);

    logic [DIV_W-1:0]      div_cnt;
    logic [2:0]            bit_cnt;
    logic [CCW_BYTE_W-1:0] shreg;
    logic                  div_wrap;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign byte_end = div_wrap && (bit_cnt == 3'd0);
    assign byte_pre = (div_cnt == DIV_PRE) && (bit_cnt == 3'd0);

    // The shifter fills with ones, so the line idles high once the last byte drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= 3'd7;
            shreg   <= '1;
            tx_d    <= 1'b1;
        end else begin
            tx_d <= shreg[CCW_BYTE_W-1];
            if (load) begin
                shreg   <= din;
                div_cnt <= '0;
                bit_cnt <= 3'd7;
            end else if (div_wrap) begin
                shreg   <= {shreg[CCW_BYTE_W-2:0], 1'b1};
                div_cnt <= '0;
                bit_cnt <= bit_cnt - 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccw_tx.sv
// rtl/ccw_tx.sv - CCW frame transmitter: fetch, checksum and framing FSM
module ccw_tx
    import ccw_pkg::*;
#(
    parameter int         BIT_DIV = 4,
    parameter logic [7:0] SYNC    = CCW_SYNC_DEFAULT,
    parameter int         IFG     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ccw_d,
    input  logic       ccw_tx_rdy,
    output logic       ccw_tx_en,
    output logic       ccw_clk,
    output logic       tx_d,
    output logic       tx_frame,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int               GAP_CLKS = IFG * BIT_DIV;
    localparam int               GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    ccw_tx_state_t    state;
    logic [7:0]       len_q;
    logic [7:0]       idx;
    logic [7:0]       csum;
    logic             err_q;
    logic [GAP_W-1:0] gap_cnt;

    logic       ser_load;
    logic [7:0] ser_din;
    logic       capture;
    logic       byte_end;
    logic       byte_pre;

    assign busy = (state != ST_IDLE);

    ccw_tx_ser #(
        .BIT_DIV (BIT_DIV)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (ser_load),
        .din      (ser_din),
        .tx_d     (tx_d),
        .byte_end (byte_end),
        .byte_pre (byte_pre)
    );

    // Every load after SYNC lands on the edge that ends bit 0 of the byte in flight.
    always_comb begin
        ser_load = 1'b0;
        ser_din  = SYNC;
        capture  = 1'b0;
        case (state)
            ST_IDLE: begin
                ser_load = ccw_tx_rdy && !ccw_tx_en;
            end
            ST_SYNC: begin
                ser_load = byte_end;
                ser_din  = len_q;
            end
            ST_LEN: begin
                ser_load = byte_end;
                if (len_q != 8'd0) begin
                    ser_din = ccw_d;
                    capture = byte_end;
                end else begin
                    ser_din = csum;
                end
            end
            ST_PAYLOAD: begin
                ser_load = byte_end;
                if (idx == len_q) begin
                    ser_din = csum;
                end else begin
                    ser_din = ccw_d;
                    capture = byte_end;
                end
            end
            default: begin
                ser_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            idx        <= '0;
            csum       <= '0;
            err_q      <= 1'b0;
            gap_cnt    <= '0;
            ccw_tx_en  <= 1'b0;
            ccw_clk    <= 1'b0;
            tx_frame   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Framing outputs trail the FSM by one clk to line up with the registered line.
            ccw_clk    <= capture;
            tx_frame   <= (state == ST_SYNC) || (state == ST_LEN) ||
                          (state == ST_PAYLOAD) || (state == ST_CSUM);
            frame_done <= (state == ST_GAP) && (gap_cnt == '0);
            frame_err  <= err_q;

            if (capture) begin
                csum <= csum_add(csum, ccw_d);
                idx  <= idx + 1'b1;
                if (!ccw_tx_rdy) begin
                    err_q <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (ser_load) begin
                        len_q <= ccw_d;
                        csum  <= '0;
                        err_q <= 1'b0;
                        idx   <= '0;
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (byte_end) begin
                        csum  <= len_q;
                        state <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    // Raise the fetch enable a clk early so ccw_d holds payload at the capture.
                    if (byte_pre && (len_q != 8'd0)) begin
                        ccw_tx_en <= 1'b1;
                    end
                    if (byte_end) begin
                        state <= (len_q != 8'd0) ? ST_PAYLOAD : ST_CSUM;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_end && (idx == len_q)) begin
                        ccw_tx_en <= 1'b0;
                        state     <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (byte_end) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccw_tx.sv
// tb/tb_ccw_tx.sv - directed self-checking bench for ccw_tx with a generator model
module tb_ccw_tx;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ccw_d;
    logic       ccw_tx_rdy;
    logic       ccw_tx_en;
    logic       ccw_clk;
    logic       tx_d;
    logic       tx_frame;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    always #5 clk = ~clk;

    ccw_tx #(
        .BIT_DIV (BD),
        .SYNC    (8'h7E),
        .IFG     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ccw_d      (ccw_d),
        .ccw_tx_rdy (ccw_tx_rdy),
        .ccw_tx_en  (ccw_tx_en),
        .ccw_clk    (ccw_clk),
        .tx_d       (tx_d),
        .tx_frame   (tx_frame),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx[$];
    int         frame_clks;
    int         pulses;
    bit         done_seen;
    bit         err_seen;
    bit         en_seen;
    bit         aborted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] out_vec();
        return {tx_d, tx_frame, busy, ccw_tx_en, ccw_clk, frame_done, frame_err};
    endfunction

    // Generator model and line deserializer; runs one frame, sampling on falling edges.
    task automatic run_frame(input int len, input int base, input int cut,
                             input int abort_at, input bit hold);
        int         fetch = 0;
        int         cyc   = 0;
        int         w     = 0;
        int         nb    = 0;
        logic [7:0] sh    = 8'h00;
        while (busy && w < 500) begin
            @(negedge clk);
            w++;
        end
        rx.delete();
        frame_clks = 0;
        pulses     = 0;
        done_seen  = 1'b0;
        err_seen   = 1'b0;
        en_seen    = 1'b0;
        aborted    = 1'b0;
        ccw_d      = len[7:0];
        ccw_tx_rdy = 1'b1;
        while (!done_seen && !aborted && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (ccw_tx_en) en_seen = 1'b1;
            if (ccw_clk) begin
                pulses++;
                fetch++;
            end
            if (tx_frame) begin
                if (frame_clks % BD == BD / 2) begin
                    sh = {sh[6:0], tx_d};
                    nb++;
                    if (nb % 8 == 0) rx.push_back(sh);
                end
                frame_clks++;
            end
            if (frame_done) begin
                done_seen = 1'b1;
                err_seen  = frame_err;
            end
            if (busy && !hold && (fetch >= len || fetch >= cut)) ccw_tx_rdy = 1'b0;
            if (ccw_tx_en) ccw_d = (fetch < cut) ? 8'(base + fetch) : 8'h00;
            else           ccw_d = len[7:0];
            if (abort_at >= 0 && fetch == abort_at) begin
                ccw_tx_rdy = 1'b0;
                rst        = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_mid_payload", out_vec(), 7'b1000000);
                aborted = 1'b1;
            end
        end
    endtask

    task automatic check_frame(input string name, input int len, input int base, input int cut,
                               input logic [7:0] exp_csum, input bit exp_err);
        logic [7:0] e;
        check({name, "_nbytes"}, rx.size(), len + 3);
        for (int i = 0; i < len + 2; i++) begin
            if (i == 0)      e = 8'h7E;
            else if (i == 1) e = len[7:0];
            else             e = (i - 2 < cut) ? 8'(base + i - 2) : 8'h00;
            check($sformatf("%s_byte%0d", name, i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF_FFFF, e);
        end
        check({name, "_csum"}, (len + 2 < rx.size()) ? {24'h0, rx[len + 2]} : 32'hFFFF_FFFF, exp_csum);
        check({name, "_tx_frame_clks"}, frame_clks, (len + 3) * 8 * BD);
        check({name, "_ccw_clk_pulses"}, pulses, len);
        check({name, "_frame_done"}, done_seen, 1);
        check({name, "_frame_err"}, err_seen, exp_err);
        check({name, "_tx_en_seen"}, en_seen, len != 0);
    endtask

    initial begin
        int bad;
        int g;
        bit seen;
        rst        = 1'b1;
        ccw_tx_rdy = 1'b0;
        ccw_d      = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_values", out_vec(), 7'b1000000);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_vec() != 7'b1000000) bad++;
        end
        check("idle_100", bad, 0);

        run_frame(62, 'hAB, 999, -1, 1'b0);
        check_frame("len62", 62, 'hAB, 999, 8'h0B, 1'b0);

        run_frame(0, 0, 999, -1, 1'b0);
        check_frame("len0", 0, 0, 999, 8'h00, 1'b0);

        run_frame(62, 'hAB, 10, -1, 1'b0);
        check_frame("rdy_drop", 62, 'hAB, 10, 8'h19, 1'b1);

        run_frame(62, 'hAB, 999, 5, 1'b0);
        check("abort_reached", aborted, 1);
        run_frame(62, 'h01, 999, -1, 1'b0);
        check_frame("after_rst", 62, 'h01, 999, 8'hDF, 1'b0);

        run_frame(2, 'h10, 999, -1, 1'b1);
        check_frame("b2b", 2, 'h10, 999, 8'h23, 1'b0);
        g    = 1;
        seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (tx_frame) seen = 1'b1;
            else          g++;
        end
        check("b2b_gap_clks", g, 65);
        ccw_tx_rdy = 1'b0;
        for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
        check("b2b_drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
